seq_detect_moore_param: RTL and testbench

- Parametrised Moore serial-pattern detector.
- Generalises the fixed "101" detector to a run-time programmable pattern of 1..PAT_W bits, with overlap/non-overlap mode, an input-valid qualifier and a saturating match counter.
- Sits on serial bit streams (UART/line-code framing, sync-word search) ahead of control logic that needs a registered, glitch-free match flag.

---
 rtl/seq_detect_moore_param_pkg.sv | 18 +
 rtl/seq_detect_moore_param_if.sv | 33 +++
 rtl/seq_detect_moore_param_next_state.sv | 60 ++++++
 rtl/seq_detect_moore_param.sv | 92 +++++++++
 tb/tb_seq_detect_moore_param.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_moore_param_pkg.sv
// Shared types and helpers for the programmable Moore sequence detector.
package seq_detect_pkg;

  // Width needed to hold a matched-prefix length in the range 0..pat_w.
  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // No leading pattern bits matched yet.
  localparam int STATE_IDLE = 0;

  // Whether a suffix of a completed match may seed the next match.
  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

endpackage

// File: rtl/seq_detect_moore_param_if.sv
// Configuration, serial input and status bundle for the sequence detector.
interface seq_detect_moore_param_if
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);

  localparam int SW = state_w(PAT_W);

  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [SW-1:0]    cfg_len;
  logic             cfg_ovl;
  logic             in_valid;
  logic             x;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;
  logic [SW-1:0]    state_o;

  modport master (
    output cfg_load, cfg_pat, cfg_len, cfg_ovl, in_valid, x, cnt_clr,
    input  y, match_cnt, cfg_err, state_o
  );

  modport slave (
    input  cfg_load, cfg_pat, cfg_len, cfg_ovl, in_valid, x, cnt_clr,
    output y, match_cnt, cfg_err, state_o
  );

endinterface

// File: rtl/seq_detect_moore_param_next_state.sv
// Combinational KMP-style fallback: given the matched-prefix length and the
// incoming bit, find the longest pattern prefix that is a suffix of the history.
module seq_next_state
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  localparam int SW = state_w(PAT_W)
) (
  input  logic [SW-1:0]    k_i,
  input  logic             x_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [SW-1:0]    len_i,
  input  ovl_mode_e        ovl_i,
  output logic [SW-1:0]    next_o
);

  // Pattern bit i in line order: bit 0 is the first bit expected (pat[len-1]).
  function automatic logic patBit(input logic [PAT_W-1:0] pat, input int len, input int i);
    return 1'(pat >> (len - 1 - i));
  endfunction

  logic [SW-1:0] kEff;
  logic          found;
  logic          matchOk;
  logic          histBit;

  // Try candidate lengths from longest to shortest; the first fit wins. The
  // history is the first k pattern bits followed by x, so only pattern bits
  // and x are ever compared.
  always_comb begin
    kEff    = k_i;
    found   = 1'b0;
    matchOk = 1'b0;
    histBit = 1'b0;
    next_o  = '0;
    if (ovl_i == OVL_OFF && k_i == len_i) begin
      kEff = '0;
    end
    for (int j = PAT_W; j >= 1; j--) begin
      matchOk = 1'b0;
      if (!found && j <= int'(len_i) && j <= int'(kEff) + 1) begin
        matchOk = 1'b1;
        for (int m = 0; m < PAT_W; m++) begin
          if (m < j) begin
            histBit = (m == j - 1) ? x_i
                                   : patBit(pat_i, int'(len_i), int'(kEff) + 1 - j + m);
            if (histBit != patBit(pat_i, int'(len_i), m)) begin
              matchOk = 1'b0;
            end
          end
        end
        if (matchOk) begin
          found  = 1'b1;
          next_o = SW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_moore_param.sv
// Programmable Moore serial-pattern detector with overlap control, input
// qualifier, saturating match counter and sticky illegal-length flag.
module seq_detect_moore_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(8'b0000_0101),
  parameter int               LEN_RST = 3
) (
  input logic                        clk,
  input logic                        rst,
  seq_detect_moore_param_if.slave    bus
);

  localparam int SW = state_w(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [SW-1:0]    len_q, len_d;
  ovl_mode_e        ovl_q, ovl_d;
  logic             cfgErr_q, cfgErr_d;
  logic [SW-1:0]    state_q, state_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] matchCnt_q, matchCnt_d;
  logic [SW-1:0]    nextState;
  logic             lenIllegal;

  seq_next_state #(.PAT_W(PAT_W)) uNext (
    .k_i    (state_q),
    .x_i    (bus.x),
    .pat_i  (pat_q),
    .len_i  (len_q),
    .ovl_i  (ovl_q),
    .next_o (nextState)
  );

  // Next-state, Moore output and counter decisions; config load overrides data.
  always_comb begin
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    cfgErr_d   = cfgErr_q;
    state_d    = state_q;
    y_d        = y_q;
    matchCnt_d = matchCnt_q;
    lenIllegal = (bus.cfg_len == '0) || (int'(bus.cfg_len) > PAT_W);
    if (bus.cfg_load) begin
      pat_d    = bus.cfg_pat;
      len_d    = bus.cfg_len;
      ovl_d    = ovl_mode_e'(bus.cfg_ovl);
      cfgErr_d = lenIllegal;
      state_d  = SW'(STATE_IDLE);
      y_d      = 1'b0;
    end else if (bus.in_valid && !cfgErr_q) begin
      state_d = nextState;
      y_d     = (nextState == len_q);
      if (y_d && matchCnt_q != '1) begin
        matchCnt_d = matchCnt_q + 1'b1;
      end
    end
    if (bus.cnt_clr) begin
      matchCnt_d = '0;
    end
  end

  // State, config and status registers with asynchronous return to defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q      <= PAT_RST;
      len_q      <= SW'(LEN_RST);
      ovl_q      <= OVL_ON;
      cfgErr_q   <= 1'b0;
      state_q    <= SW'(STATE_IDLE);
      y_q        <= 1'b0;
      matchCnt_q <= '0;
    end else begin
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      cfgErr_q   <= cfgErr_d;
      state_q    <= state_d;
      y_q        <= y_d;
      matchCnt_q <= matchCnt_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.match_cnt = matchCnt_q;
  assign bus.cfg_err   = cfgErr_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Directed scoreboard bench for the programmable Moore sequence detector.
module tb_seq_detect_moore_param;
  import seq_detect_pkg::*;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int SW    = state_w(PAT_W);

  logic clk;
  logic rst;

  seq_detect_moore_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detect_moore_param #(
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .PAT_RST (8'b0000_0101),
    .LEN_RST (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string name;
    logic  y;
    int    cnt;
    int    st;
    logic  err;
  } exp_t;

  exp_t expQ[$];
  exp_t drvE;
  exp_t monE;
  exp_t rstE;
  int   checks = 0;
  int   errors = 0;
  logic expErr = 1'b0;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input exp_t e);
    logic [CNT_W-1:0] eCnt;
    logic [SW-1:0]    eSt;
    eCnt = CNT_W'(e.cnt);
    eSt  = SW'(e.st);
    checks++;
    if (bus.y !== e.y) begin
      errors++;
      $display("[TB] FAIL %s y: got %0b required %0b", e.name, bus.y, e.y);
    end
    checks++;
    if (bus.match_cnt !== eCnt) begin
      errors++;
      $display("[TB] FAIL %s match_cnt: got %0d required %0d", e.name, bus.match_cnt, eCnt);
    end
    checks++;
    if (bus.state_o !== eSt) begin
      errors++;
      $display("[TB] FAIL %s state: got %0d required %0d", e.name, bus.state_o, eSt);
    end
    checks++;
    if (bus.cfg_err !== e.err) begin
      errors++;
      $display("[TB] FAIL %s cfg_err: got %0b required %0b", e.name, bus.cfg_err, e.err);
    end
  endtask

  // Monitor: whenever an expectation is pending, compare on the falling edge.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monE = expQ.pop_front();
      checkOutput(monE);
    end
  end

  task automatic applyStimulus(input string name, input logic load, input logic [7:0] pat,
                               input logic [3:0] len, input logic ovl, input logic valid,
                               input logic xb, input logic clr, input logic eY,
                               input int eCnt, input int eSt, input logic eErr);
    bus.cfg_load = load;
    bus.cfg_pat  = pat;
    bus.cfg_len  = len;
    bus.cfg_ovl  = ovl;
    bus.in_valid = valid;
    bus.x        = xb;
    bus.cnt_clr  = clr;
    @(posedge clk);
    drvE.name = name;
    drvE.y    = eY;
    drvE.cnt  = eCnt;
    drvE.st   = eSt;
    drvE.err  = eErr;
    expQ.push_back(drvE);
    #1;
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b0;
  endtask

  task automatic bitStep(input string name, input logic xb, input logic eY,
                         input int eCnt, input int eSt);
    applyStimulus(name, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, xb, 1'b0, eY, eCnt, eSt, expErr);
  endtask

  task automatic idleStep(input string name, input logic xb, input logic eY,
                          input int eCnt, input int eSt);
    applyStimulus(name, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, xb, 1'b0, eY, eCnt, eSt, expErr);
  endtask

  task automatic loadStep(input string name, input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic clr, input int eCnt, input logic eErr);
    expErr = eErr;
    applyStimulus(name, 1'b1, pat, len, ovl, 1'b0, 1'b0, clr, 1'b0, eCnt, 0, eErr);
  endtask

  // Assert reset between edges and check before the next rising edge.
  task automatic pulseReset(input string name);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    rstE.name = name;
    rstE.y    = 1'b0;
    rstE.cnt  = 0;
    rstE.st   = 0;
    rstE.err  = 1'b0;
    checkOutput(rstE);
    expErr = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.cfg_load = 1'b0;
    bus.cfg_pat  = '0;
    bus.cfg_len  = '0;
    bus.cfg_ovl  = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = 1'b0;
    bus.cnt_clr  = 1'b0;
    drvE.name = "reset";
    drvE.y    = 1'b0;
    drvE.cnt  = 0;
    drvE.st   = 0;
    drvE.err  = 1'b0;
    expQ.push_back(drvE);
    @(negedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] default pattern 101, overlap");
    bitStep("t1 b1", 1'b1, 1'b0, 0, 1);
    bitStep("t1 b2", 1'b0, 1'b0, 0, 2);
    bitStep("t1 b3", 1'b1, 1'b1, 1, 3);
    bitStep("t1 b4", 1'b0, 1'b0, 1, 2);
    bitStep("t1 b5", 1'b1, 1'b1, 2, 3);

    $display("[TB] pattern 101, non-overlap");
    loadStep("t2 load", 8'b101, 4'd3, 1'b0, 1'b1, 0, 1'b0);
    bitStep("t2 b1", 1'b1, 1'b0, 0, 1);
    bitStep("t2 b2", 1'b0, 1'b0, 0, 2);
    bitStep("t2 b3", 1'b1, 1'b1, 1, 3);
    bitStep("t2 b4", 1'b0, 1'b0, 1, 0);
    bitStep("t2 b5", 1'b1, 1'b0, 1, 1);

    $display("[TB] pattern 1101, fallback");
    loadStep("t3 load", 8'b1101, 4'd4, 1'b1, 1'b1, 0, 1'b0);
    bitStep("t3 b1", 1'b1, 1'b0, 0, 1);
    bitStep("t3 b2", 1'b1, 1'b0, 0, 2);
    bitStep("t3 b3", 1'b1, 1'b0, 0, 2);
    bitStep("t3 b4", 1'b0, 1'b0, 0, 3);
    bitStep("t3 b5", 1'b1, 1'b1, 1, 4);

    $display("[TB] in_valid gaps");
    loadStep("t4 load", 8'b101, 4'd3, 1'b1, 1'b1, 0, 1'b0);
    bitStep("t4 b1", 1'b1, 1'b0, 0, 1);
    idleStep("t4 idle1", 1'b1, 1'b0, 0, 1);
    idleStep("t4 idle2", 1'b0, 1'b0, 0, 1);
    idleStep("t4 idle3", 1'b1, 1'b0, 0, 1);
    bitStep("t4 b2", 1'b0, 1'b0, 0, 2);
    bitStep("t4 b3", 1'b1, 1'b1, 1, 3);
    idleStep("t4 hold1", 1'b0, 1'b1, 1, 3);
    idleStep("t4 hold2", 1'b1, 1'b1, 1, 3);
    bitStep("t4 b4", 1'b1, 1'b0, 1, 1);

    $display("[TB] len 1, counter saturation and clear");
    loadStep("t5 load", 8'b1, 4'd1, 1'b1, 1'b1, 0, 1'b0);
    bitStep("t5 b1", 1'b1, 1'b1, 1, 1);
    bitStep("t5 b2", 1'b1, 1'b1, 2, 1);
    bitStep("t5 b3", 1'b1, 1'b1, 3, 1);
    bitStep("t5 b4", 1'b1, 1'b1, 3, 1);
    bitStep("t5 b5", 1'b1, 1'b1, 3, 1);
    applyStimulus("t5 clr", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 1'b0);
    bitStep("t5 b6", 1'b0, 1'b0, 0, 0);

    $display("[TB] full-width pattern 10101010");
    loadStep("t6 load", 8'b1010_1010, 4'd8, 1'b1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bitStep("t6 prefix", (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 0, i + 1);
    end
    bitStep("t6 b8", 1'b0, 1'b1, 1, 8);
    bitStep("t6 b9", 1'b1, 1'b0, 1, 7);
    bitStep("t6 b10", 1'b0, 1'b1, 2, 8);

    $display("[TB] illegal lengths and mid-stream reset");
    loadStep("t7 len0", 8'b101, 4'd0, 1'b1, 1'b0, 2, 1'b1);
    bitStep("t7 e1", 1'b1, 1'b0, 2, 0);
    bitStep("t7 e2", 1'b0, 1'b0, 2, 0);
    bitStep("t7 e3", 1'b1, 1'b0, 2, 0);
    loadStep("t7 len9", 8'b101, 4'd9, 1'b1, 1'b0, 2, 1'b1);
    bitStep("t7 e4", 1'b1, 1'b0, 2, 0);
    loadStep("t7 legal", 8'b101, 4'd3, 1'b1, 1'b1, 0, 1'b0);
    bitStep("t7 b1", 1'b1, 1'b0, 0, 1);
    bitStep("t7 b2", 1'b0, 1'b0, 0, 2);
    bitStep("t7 b3", 1'b1, 1'b1, 1, 3);
    bitStep("t7 b4", 1'b0, 1'b0, 1, 2);
    pulseReset("t7 reset");
    bitStep("t7 r1", 1'b1, 1'b0, 0, 1);
    bitStep("t7 r2", 1'b0, 1'b0, 0, 2);
    bitStep("t7 r3", 1'b1, 1'b1, 1, 3);
    bitStep("t7 r4", 1'b0, 1'b0, 1, 2);
    bitStep("t7 r5", 1'b1, 1'b1, 2, 3);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations required 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
